// File: rtl/ingreso_codigo.sv
// Keypad code-entry lock: debounced key capture, 4-digit BCD buffer,
// code check with timed open/error/lockout indications.
module ingreso_codigo #(
  parameter int unsigned DEBOUNCE    = 3,
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int unsigned OPEN_CYCLES = 500,
  parameter int unsigned ERR_CYCLES  = 100,
  parameter int unsigned LOCK_CYCLES = 3000,
  parameter int unsigned MAX_FAILS   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  tecla,
  output logic [15:0] buffer,
  output logic [2:0]  n_digitos,
  output logic        tecla_valida,
  output logic        abierto,
  output logic        error,
  output logic        bloqueado
);

  localparam logic [2:0] S_ENTRY  = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_OK     = 3'd2;
  localparam logic [2:0] S_FAIL   = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;

  localparam logic [3:0]  DB     = 4'(DEBOUNCE);
  localparam logic [2:0]  MF     = 3'(MAX_FAILS);
  localparam logic [15:0] T_OPEN = 16'(OPEN_CYCLES);
  localparam logic [15:0] T_ERR  = 16'(ERR_CYCLES);
  localparam logic [15:0] T_LOCK = 16'(LOCK_CYCLES);

  logic        pressed_q, pressed_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  last_q, last_d;
  logic        accept;
  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  fails_q, fails_d;
  logic [15:0] buffer_q, buffer_d;
  logic [2:0]  n_q, n_d;
  logic        valid_q, abierto_q, error_q, bloq_q;

  // tecla[4] set means no key is down
  always_comb begin
    pressed_d = pressed_q;
    cnt_d     = cnt_q;
    last_d    = tecla;
    accept    = 1'b0;
    if (!pressed_q) begin
      if (!tecla[4]) begin
        if (cnt_q != 4'd0 && tecla == last_q)
          cnt_d = 4'(cnt_q + 4'd1);
        else
          cnt_d = 4'd1;
        if (cnt_d == DB) begin
          accept    = 1'b1;
          pressed_d = 1'b1;
          cnt_d     = 4'd0;
        end
      end else begin
        cnt_d = 4'd0;
      end
    end else begin
      if (tecla[4]) begin
        cnt_d = 4'(cnt_q + 4'd1);
        if (cnt_d == DB) begin
          pressed_d = 1'b0;
          cnt_d     = 4'd0;
        end
      end else begin
        cnt_d = 4'd0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    fails_d  = fails_q;
    buffer_d = buffer_q;
    n_d      = n_q;
    unique case (state_q)
      S_ENTRY: begin
        if (accept) begin
          if (tecla < 5'd10) begin
            if (n_q < 3'd4) begin
              buffer_d = {buffer_q[11:0], tecla[3:0]};
              n_d      = 3'(n_q + 3'd1);
            end
          end else if (tecla == 5'd15) begin
            buffer_d = 16'h0;
            n_d      = 3'd0;
          end else if (tecla == 5'd14) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (n_q == 3'd4 && buffer_q == CODE) begin
          fails_d = 3'd0;
          state_d = S_OK;
          timer_d = T_OPEN;
        end else begin
          fails_d = 3'(fails_q + 3'd1);
          if (fails_d == MF) begin
            state_d = S_LOCKED;
            timer_d = T_LOCK;
          end else begin
            state_d = S_FAIL;
            timer_d = T_ERR;
          end
        end
      end
      S_OK, S_FAIL, S_LOCKED: begin
        if (timer_q <= 16'd1) begin
          state_d  = S_ENTRY;
          timer_d  = 16'd0;
          buffer_d = 16'h0;
          n_d      = 3'd0;
          if (state_q == S_LOCKED) fails_d = 3'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = S_ENTRY;
        timer_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed_q <= 1'b0;
      cnt_q     <= 4'd0;
      last_q    <= 5'd0;
      state_q   <= S_ENTRY;
      timer_q   <= 16'd0;
      fails_q   <= 3'd0;
      buffer_q  <= 16'h0;
      n_q       <= 3'd0;
      valid_q   <= 1'b0;
      abierto_q <= 1'b0;
      error_q   <= 1'b0;
      bloq_q    <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      fails_q   <= fails_d;
      buffer_q  <= buffer_d;
      n_q       <= n_d;
      valid_q   <= accept;
      abierto_q <= (state_d == S_OK);
      error_q   <= (state_d == S_FAIL);
      bloq_q    <= (state_d == S_LOCKED);
    end
  end

  assign buffer       = buffer_q;
  assign n_digitos    = n_q;
  assign tecla_valida = valid_q;
  assign abierto      = abierto_q;
  assign error        = error_q;
  assign bloqueado    = bloq_q;

endmodule
